char_stream_unit: RTL

Parametrised end-of-run result streamer for the processor top level. It watches the core's output word for a programmable end code, then drains a character buffer one entry at a time at a programmable pace. The buffer is written by the core through a write port. Unlike the fixed 100-entry, fixed-rate drain in the current top level, it has a run-time length, a valid/ready output handshake, a done indication and a rearm path.

---
 rtl/char_stream_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/char_stream_unit.sv
// End-of-run result streamer: waits for END_CODE on the core output word, then
// drains the character buffer through a paced valid/ready port until rearmed.
module char_stream_unit #(
    parameter int DATAWIDTH   = 36,
    parameter int CHARW       = 8,
    parameter int DEPTH       = 100,
    parameter int ADDRW       = 7,
    parameter int PACE_CYCLES = 5,
    parameter int END_CODE    = 500
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATAWIDTH-1:0] watch_data,
    input  logic                 wr_en,
    input  logic [ADDRW-1:0]     wr_addr,
    input  logic [CHARW-1:0]     wr_data,
    input  logic [ADDRW:0]       len,
    input  logic                 rearm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CHARW-1:0]     out_data,
    output logic [ADDRW-1:0]     out_index,
    output logic                 end_flag,
    output logic                 busy,
    output logic                 done
);

    localparam int PW = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
    localparam logic [PW-1:0]        PACE_LAST = PW'(PACE_CYCLES - 1);
    localparam logic [ADDRW:0]       DEPTH_L   = (ADDRW + 1)'(DEPTH);
    localparam logic [DATAWIDTH-1:0] END_L     = DATAWIDTH'(END_CODE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PACE,
        S_SEND,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CHARW-1:0]    mem_q [DEPTH];
    logic [ADDRW:0]      len_q, len_d;
    logic [ADDRW-1:0]    pos_q, pos_d;
    logic [PW-1:0]       pace_q, pace_d;
    logic [CHARW-1:0]    data_q, data_d;
    logic [ADDRW-1:0]    index_q, index_d;
    logic                end_q, end_d;

    // Buffer is deliberately not reset; out-of-range writes are dropped.
    always_ff @(posedge clock) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_L)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            pos_q   <= '0;
            pace_q  <= '0;
            data_q  <= '0;
            index_q <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pos_q   <= pos_d;
            pace_q  <= pace_d;
            data_q  <= data_d;
            index_q <= index_d;
            end_q   <= end_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pos_d   = pos_q;
        pace_d  = pace_q;
        data_d  = data_q;
        index_d = index_q;
        end_d   = end_q;

        // rearm overrides detection and handshake completion alike
        if (rearm) begin
            state_d = S_IDLE;
            end_d   = 1'b0;
            pos_d   = '0;
            pace_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (watch_data == END_L) begin
                        end_d   = 1'b1;
                        pos_d   = '0;
                        pace_d  = '0;
                        len_d   = (len > DEPTH_L) ? DEPTH_L : len;
                        state_d = (len == '0) ? S_DONE : S_PACE;
                    end
                end
                S_PACE: begin
                    if (pace_q == PACE_LAST) begin
                        // registered read: a same-cycle write to pos is not seen
                        data_d  = mem_q[pos_q];
                        index_d = pos_q;
                        pace_d  = '0;
                        state_d = S_SEND;
                    end else begin
                        pace_d = pace_q + PW'(1);
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if ({1'b0, pos_q} == (len_q - (ADDRW + 1)'(1))) begin
                            state_d = S_DONE;
                        end else begin
                            pos_d   = pos_q + ADDRW'(1);
                            pace_d  = '0;
                            state_d = S_PACE;
                        end
                    end
                end
                S_DONE: begin
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign out_valid = (state_q == S_SEND);
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q == S_PACE) || (state_q == S_SEND);
    assign out_data  = data_q;
    assign out_index = index_q;
    assign end_flag  = end_q;

endmodule
